// File: rtl/dual_tone_detector_if.sv
// Signal bundle between the frequency analyzer manager and dual_tone_detector.
// Carries the sample/control levels in, the accumulated tone times out, and the FSM state for debug.
interface dual_tone_detector_if;
    // No valid/ready handshake: every signal is a level, sampled or updated on each rising clock edge.
    logic        sample_data;
    logic        enable;
    logic        clear;
    logic [31:0] f0_value;
    logic [31:0] f1_value;
    logic        f0_active;
    logic        f1_active;
    logic [1:0]  dbg_state;

    modport master (
        output sample_data, enable, clear,
        input  f0_value, f1_value, f0_active, f1_active, dbg_state
    );

    modport slave (
        input  sample_data, enable, clear,
        output f0_value, f1_value, f0_active, f1_active, dbg_state
    );
endinterface

// File: rtl/dual_tone_detector.sv
// Measures the rising-edge period of a 1-bit sample stream, classifies it as tone F0/F1 and accumulates tone time.
// Optional macro DUAL_TONE_DETECTOR_GLITCH_FILTER_EN adds a GLITCH_CYCLES stable-level filter before edge detection.
module dual_tone_detector #(
    parameter int unsigned FREQUENCY0           = 5000,
    parameter int unsigned FREQUENCY1           = 10000,
    parameter int unsigned FREQUENCY0_DEVIATION = 20,
    parameter int unsigned FREQUENCY1_DEVIATION = 20,
    parameter int unsigned CLOCK_FREQUENCY      = 100000000,
    parameter int unsigned GLITCH_CYCLES        = 4
) (
    input  logic                  s00_axi_aclk,
    input  logic                  s00_axi_aresetn,
    dual_tone_detector_if.slave   bus
);
    localparam logic [31:0] P0_MIN    = 32'(CLOCK_FREQUENCY / (FREQUENCY0 + FREQUENCY0_DEVIATION));
    localparam logic [31:0] P0_MAX    = 32'(CLOCK_FREQUENCY / (FREQUENCY0 - FREQUENCY0_DEVIATION));
    localparam logic [31:0] P1_MIN    = 32'(CLOCK_FREQUENCY / (FREQUENCY1 + FREQUENCY1_DEVIATION));
    localparam logic [31:0] P1_MAX    = 32'(CLOCK_FREQUENCY / (FREQUENCY1 - FREQUENCY1_DEVIATION));
    localparam logic [31:0] P_TIMEOUT = (P0_MAX > P1_MAX) ? P0_MAX : P1_MAX;
    localparam logic [31:0] P_EXPIRE  = P_TIMEOUT + 32'd1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    logic sync1_q, sync2_q, prev_q, edge_q;
    logic level;

`ifdef DUAL_TONE_DETECTOR_GLITCH_FILTER_EN
    localparam int unsigned RUN_W = $clog2(GLITCH_CYCLES + 1);
    logic             filt_q;
    logic [RUN_W-1:0] run_q;

    // A new level is adopted only after GLITCH_CYCLES consecutive disagreeing samples.
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            filt_q <= 1'b0;
            run_q  <= '0;
        end else if (sync2_q == filt_q) begin
            run_q <= '0;
        end else if (run_q == RUN_W'(GLITCH_CYCLES - 1)) begin
            filt_q <= sync2_q;
            run_q  <= '0;
        end else begin
            run_q <= run_q + RUN_W'(1);
        end
    end
    assign level = filt_q;
`else
    assign level = sync2_q;
`endif

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= bus.sample_data;
            sync2_q <= sync1_q;
            prev_q  <= level;
            edge_q  <= level & ~prev_q;
        end
    end

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        hit_q, hit_d;
    logic [31:0] per_q, per_d;
    logic [31:0] f0_value_q, f0_value_d;
    logic [31:0] f1_value_q, f1_value_d;
    logic        f0_active_q, f0_active_d;
    logic        f1_active_q, f1_active_d;

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hit_q       <= 1'b0;
            per_q       <= '0;
            f0_value_q  <= '0;
            f1_value_q  <= '0;
            f0_active_q <= 1'b0;
            f1_active_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hit_q       <= hit_d;
            per_q       <= per_d;
            f0_value_q  <= f0_value_d;
            f1_value_q  <= f1_value_d;
            f0_active_q <= f0_active_d;
            f1_active_q <= f1_active_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hit_d       = 1'b0;
        per_d       = per_q;
        f0_value_d  = f0_value_q;
        f1_value_d  = f1_value_q;
        f0_active_d = f0_active_q;
        f1_active_d = f1_active_q;

        // A period captured on the previous clock is classified here; F0 wins on overlap.
        if (hit_q) begin
            if (per_q >= P0_MIN && per_q <= P0_MAX) begin
                f0_value_d  = sat_add(f0_value_q, per_q);
                f0_active_d = 1'b1;
                f1_active_d = 1'b0;
            end else if (per_q >= P1_MIN && per_q <= P1_MAX) begin
                f1_value_d  = sat_add(f1_value_q, per_q);
                f1_active_d = 1'b1;
                f0_active_d = 1'b0;
            end else begin
                f0_active_d = 1'b0;
                f1_active_d = 1'b0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (bus.enable) state_d = ST_ARM;
            end
            ST_ARM: begin
                if (edge_q) begin
                    cnt_d   = 32'd1;
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (edge_q) begin
                    hit_d = 1'b1;
                    per_d = cnt_q;
                    cnt_d = 32'd1;
                end else begin
                    cnt_d = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
                    if (cnt_q == P_EXPIRE) begin
                        f0_active_d = 1'b0;
                        f1_active_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!bus.enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            hit_d   = 1'b0;
        end

        if (bus.clear) begin
            f0_value_d  = '0;
            f1_value_d  = '0;
            f0_active_d = 1'b0;
            f1_active_d = 1'b0;
            cnt_d       = '0;
            hit_d       = 1'b0;
            state_d     = bus.enable ? ST_ARM : ST_IDLE;
        end
    end

    assign bus.f0_value  = f0_value_q;
    assign bus.f1_value  = f1_value_q;
    assign bus.f0_active = f0_active_q;
    assign bus.f1_active = f1_active_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_dual_tone_detector.sv
// Randomized self-checking bench for dual_tone_detector (default build, CLOCK_FREQUENCY=1 MHz).
// A timestamp-based tone model is compared every cycle; directed scenarios pin it with literal values.
module tb_dual_tone_detector;
    // Windows at 1 MHz: F0 [199,200], F1 [99,100], timeout 200.
    localparam longint F0_LO = 199;
    localparam longint F0_HI = 200;
    localparam longint F1_LO = 99;
    localparam longint F1_HI = 100;
    localparam longint T_OUT = 200;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, sample, en, clr;

    dual_tone_detector_if bus_if();
    assign bus_if.sample_data = sample;
    assign bus_if.enable      = en;
    assign bus_if.clear       = clr;

    dual_tone_detector #(
        .CLOCK_FREQUENCY(1000000)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .bus             (bus_if)
    );

    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint m_f0 = 0, m_f1 = 0, m_last = 0, m_pend_p = 0;
    bit     m_a0 = 0, m_a1 = 0, m_pend = 0;
    int     m_mode = 0;         // 0 disabled, 1 waiting for first edge, 2 timing periods
    bit [4:0] hist = '0;        // hist[j] = input level sampled j clocks ago

    function automatic longint sat32(input longint v);
        return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
    endfunction

    always @(posedge clk) begin
        bit     det, np;
        longint pp;
        cyc++;
        hist = {hist[3:0], sample};
        np = 0;
        pp = 0;
        if (!rst_n) begin
            m_f0 = 0; m_f1 = 0; m_a0 = 0; m_a1 = 0;
            m_mode = 0; m_pend = 0; hist = '0;
        end else begin
            if (m_pend) begin
                if (m_pend_p >= F0_LO && m_pend_p <= F0_HI) begin
                    m_f0 = sat32(m_f0 + m_pend_p); m_a0 = 1; m_a1 = 0;
                end else if (m_pend_p >= F1_LO && m_pend_p <= F1_HI) begin
                    m_f1 = sat32(m_f1 + m_pend_p); m_a1 = 1; m_a0 = 0;
                end else begin
                    m_a0 = 0; m_a1 = 0;
                end
            end
            // An input rise is acted on 3 clocks after it is sampled.
            det = hist[3] & ~hist[4];
            if (m_mode == 0) begin
                if (en) m_mode = 1;
            end else if (m_mode == 1) begin
                if (det) begin m_last = cyc; m_mode = 2; end
            end else begin
                if (det) begin
                    np = 1; pp = cyc - m_last; m_last = cyc;
                end else if (cyc - m_last == T_OUT + 1) begin
                    m_a0 = 0; m_a1 = 0;
                end
            end
            if (!en) begin m_mode = 0; np = 0; end
            if (clr) begin
                m_f0 = 0; m_f1 = 0; m_a0 = 0; m_a1 = 0; np = 0;
                m_mode = en ? 1 : 0;
            end
            m_pend   = np;
            m_pend_p = pp;
        end
        #1;
        chk("f0_value",  bus_if.f0_value,  32'(m_f0));
        chk("f1_value",  bus_if.f1_value,  32'(m_f1));
        chk("f0_active", 32'(bus_if.f0_active), 32'(m_a0));
        chk("f1_active", 32'(bus_if.f1_active), 32'(m_a1));
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    // Square-ish wave: rises every 'period' clocks, high for 'high' clocks.
    // clear_on selects the edge whose detection cycle also carries clear (-1 for none).
    task automatic wave(input int period, input int high, input int edges,
                        input int clear_on, output longint last_rise);
        last_rise = 0;
        for (int e = 0; e < edges; e++) begin
            @(negedge clk);
            sample    = 1'b1;
            last_rise = cyc + 1;
            for (int i = 1; i < period; i++) begin
                @(negedge clk);
                if (i == high) sample = 1'b0;
                if (e == clear_on && i == 3) clr = 1'b1;
                if (e == clear_on && i == 4) clr = 1'b0;
            end
        end
    endtask

    function automatic int pick_period();
        case ($urandom_range(0, 8))
            0: return 99;
            1: return 100;
            2: return 101;
            3: return 198;
            4: return 199;
            5: return 200;
            6: return 201;
            default: return int'($urandom_range(50, 260));
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        longint lr, fall;
        int     per, hi;
        rst_n = 1'b0; sample = 1'b0; en = 1'b0; clr = 1'b0;
        tick(3);
        chk("reset_f0_value",  bus_if.f0_value, 32'd0);
        chk("reset_f1_value",  bus_if.f1_value, 32'd0);
        chk("reset_flags",     32'({bus_if.f1_active, bus_if.f0_active}), 32'd0);
        chk("reset_state",     32'(bus_if.dbg_state), 32'd0);
        rst_n = 1'b1;
        tick(2);
        en = 1'b1;
        tick(4);

        // 10 edges at 200 clk: first arms, nine periods accumulate.
        wave(200, 100, 10, -1, lr);
        chk("t1_f0_value",  bus_if.f0_value, 32'd1800);
        chk("t1_f1_value",  bus_if.f1_value, 32'd0);
        chk("t1_f0_active", 32'(bus_if.f0_active), 32'd1);

        pulse_clear();
        tick(4);
        wave(100, 50, 11, -1, lr);
        chk("t2_f1_value",  bus_if.f1_value, 32'd1000);
        chk("t2_f0_value",  bus_if.f0_value, 32'd0);
        chk("t2_f1_active", 32'(bus_if.f1_active), 32'd1);
        chk("t2_f0_active", 32'(bus_if.f0_active), 32'd0);

        tick(30);
        wave(150, 75, 8, -1, lr);
        chk("t3_f1_value", bus_if.f1_value, 32'd1000);
        chk("t3_f0_value", bus_if.f0_value, 32'd0);
        chk("t3_flags",    32'({bus_if.f1_active, bus_if.f0_active}), 32'd0);

        // Lock on F0, then hold low until the period timeout drops the flag.
        pulse_clear();
        tick(4);
        wave(200, 100, 3, -1, lr);
        chk("t4_f0_locked", 32'(bus_if.f0_active), 32'd1);
        for (int i = 0; i < 400 && bus_if.f0_active; i++) @(negedge clk);
        fall = cyc;
        chk("t4_f0_fell",       32'(bus_if.f0_active), 32'd0);
        chk("t4_fall_delay",    32'(fall - lr), 32'd204);
        chk("t4_f0_value_held", bus_if.f0_value, 32'd400);

        // clear coincides with a detected edge; that edge is dropped.
        wave(200, 100, 2, -1, lr);
        chk("t5_before_clear", bus_if.f0_value, 32'd600);
        wave(200, 100, 1, 0, lr);
        chk("t5_cleared", bus_if.f0_value, 32'd0);
        wave(200, 100, 1, -1, lr);
        chk("t5_arm_only", bus_if.f0_value, 32'd0);
        wave(200, 100, 1, -1, lr);
        chk("t5_first_acc",    bus_if.f0_value, 32'd200);
        chk("t5_first_active", 32'(bus_if.f0_active), 32'd1);

        // One-clock reset in the middle of a measurement.
        tick(3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_f0_value", bus_if.f0_value, 32'd0);
        chk("t6_flags",    32'({bus_if.f1_active, bus_if.f0_active}), 32'd0);
        chk("t6_state",    32'(bus_if.dbg_state), 32'd0);
        tick(4);

        // Randomized bursts with occasional clear and enable drops.
        for (int b = 0; b < 25; b++) begin
            case ($urandom_range(0, 9))
                0: pulse_clear();
                1: begin
                    en = 1'b0;
                    tick(int'($urandom_range(1, 20)));
                    en = 1'b1;
                end
                default: ;
            endcase
            per = pick_period();
            hi  = int'($urandom_range(1, per - 1));
            wave(per, hi, int'($urandom_range(2, 5)), -1, lr);
        end

        tick(10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "time limit");
    end
endmodule
